// File: rtl/int_fmt_pkg.sv
// Shared types and constants for the integer-to-BCD formatter.
package int_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV1 = 2'd1,
    DIV2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BCD_W = 4;
  localparam int REM_W = 5;
  localparam logic [REM_W-1:0] DEC_BASE = 5'd10;

endpackage

// File: rtl/int_to_bcd_if.sv
// Operand/result handshake bundle between producer, formatter and print path.
interface int_to_bcd_if
  import int_fmt_pkg::*;
#(
  parameter int W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic             out_neg;
  logic [BCD_W-1:0] out_hund;
  logic [BCD_W-1:0] out_tens;
  logic [BCD_W-1:0] out_ones;
  logic             busy;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_neg, out_hund, out_tens, out_ones, busy
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_neg, out_hund, out_tens, out_ones, busy
  );

endinterface

// File: rtl/div10_step.sv
// One restoring division step by ten: shift in a dividend bit, conditionally subtract.
module div10_step
  import int_fmt_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_bit,
  output logic [BCD_W-1:0] o_rem,
  output logic             o_q
);

  logic [REM_W:0] w_trial;

  assign w_trial = {i_rem, i_bit};
  assign o_q     = (w_trial >= {1'b0, DEC_BASE});
  // Result is always below ten, so the low nibble carries the full remainder.
  assign o_rem   = o_q ? (w_trial[BCD_W-1:0] - DEC_BASE[BCD_W-1:0]) : w_trial[BCD_W-1:0];

endmodule

// File: rtl/int_to_bcd.sv
// Sign/magnitude split followed by two shift-subtract divisions by ten -> sign + 3 BCD digits.
// state | meaning
// IDLE  | waiting for operand, in_ready high
// DIV1  | magnitude / 10, remainder -> ones
// DIV2  | quotient / 10, remainder -> tens, quotient -> hundreds
// DONE  | result presented until out_ready
module int_to_bcd
  import int_fmt_pkg::*;
#(
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst,
  int_to_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_neg;
  logic [W-1:0]     r_dvd;
  logic [W-2:0]     r_quo;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_ones;
  logic             r_out_neg;
  logic [BCD_W-1:0] r_out_hund;
  logic [BCD_W-1:0] r_out_tens;
  logic [BCD_W-1:0] r_out_ones;

  logic             w_neg;
  logic [W-1:0]     w_mag;
  logic [BCD_W-1:0] w_rem;
  logic             w_q;
  logic [W-1:0]     w_quo_nxt;
  logic             w_last;

  assign w_neg     = bus.in_signed & bus.in_data[W-1];
  // Negating the signed minimum wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign w_mag     = w_neg ? (~bus.in_data + W'(1)) : bus.in_data;
  assign w_quo_nxt = {r_quo, w_q};
  assign w_last    = (r_cnt == CNT_LAST);

  div10_step u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[W-1]),
    .o_rem (w_rem),
    .o_q   (w_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = DIV1;
      DIV1:    if (w_last)        w_state_nxt = DIV2;
      DIV2:    if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_neg      <= 1'b0;
      r_dvd      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_ones     <= '0;
      r_out_neg  <= 1'b0;
      r_out_hund <= '0;
      r_out_tens <= '0;
      r_out_ones <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_neg <= w_neg;
            r_dvd <= w_mag;
            r_quo <= '0;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        DIV1, DIV2: begin
          r_dvd <= {r_dvd[W-2:0], 1'b0};
          r_quo <= w_quo_nxt[W-2:0];
          r_rem <= {1'b0, w_rem};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            if (r_state == DIV1) begin
              r_ones <= w_rem;
              r_dvd  <= w_quo_nxt;
            end else begin
              r_out_neg  <= r_neg;
              r_out_ones <= r_ones;
              r_out_tens <= w_rem;
              r_out_hund <= w_quo_nxt[BCD_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_neg   = r_out_neg;
  assign bus.out_hund  = r_out_hund;
  assign bus.out_tens  = r_out_tens;
  assign bus.out_ones  = r_out_ones;

endmodule

// File: tb/tb_int_to_bcd.sv
// Scoreboard bench for int_to_bcd: expected digits queued at accept, compared at output handshake.
module tb_int_to_bcd;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [12:0] sb_q[$];

  int_to_bcd_if #(.W(8)) bus ();

  int_to_bcd #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] model(input logic [7:0] d, input logic s);
    logic n;
    int   mag;
    n   = s & d[7];
    mag = n ? (256 - int'(d)) : int'(d);
    return {n, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [12:0] e;
        e = sb_q.pop_front();
        check("result", 32'({bus.out_neg, bus.out_hund, bus.out_tens, bus.out_ones}), 32'(e));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic s);
    int i;
    for (i = 0; i < 100; i++) begin
      if (bus.in_ready) break;
      @(posedge clk); #1;
    end
    if (i == 100) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = s;
    sb_q.push_back(model(d, s));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.in_ready && sb_q.size() == 0) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_outputs",   32'({bus.out_neg, bus.out_hund, bus.out_tens, bus.out_ones}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // latency and single-pulse valid with out_ready tied high
    send(8'd10, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 15) check("lat_before_e16", 32'(bus.out_valid), 32'd0);
      if (k == 16) check("lat_at_e16",     32'(bus.out_valid), 32'd1);
      if (k == 17) check("valid_pulse",    32'(bus.out_valid), 32'd0);
    end
    wait_done();

    send(8'hF6, 1'b1); wait_done();
    send(8'h80, 1'b1); wait_done();
    send(8'h80, 1'b0); wait_done();
    send(8'hFF, 1'b0); wait_done();
    send(8'h00, 1'b0); wait_done();
    send(8'h00, 1'b1); wait_done();
    send(8'h7F, 1'b1); wait_done();
    send(8'hFF, 1'b1); wait_done();
    for (int r = 0; r < 12; r++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_done();
    end

    // backpressure
    bus.out_ready = 1'b0;
    send(8'd42, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    check("bp_valid_seen", 32'(ok), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd7;
    bus.in_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_digits",    32'({bus.out_neg, bus.out_hund, bus.out_tens, bus.out_ones}), 32'h042);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'(bus.in_ready), 32'd1);
    sb_q.push_back(model(8'd7, 1'b0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_second_accepted", 32'(bus.busy), 32'd1);
    wait_done();

    // reset during DIV2
    send(8'd200, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    check("mid_div2_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy",      32'(bus.busy),      32'd0);
    check("arst_outputs",   32'({bus.out_neg, bus.out_hund, bus.out_tens, bus.out_ones}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'd99, 1'b0);
    wait_done();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
